instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the 5-stage pipelined CPU. It owns the program counter, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and presents fetched instructions with their PC to the IF/ID pipeline register. It honours downstream stall and branch redirect, inserting all-zero bubbles when no instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- stall_i  input  1  downstream (hazard) stall; IF outputs must hold
- redirect_i  input  1  taken branch/jump; squash in-flight fetch
- target_i  input  32  redirect PC; bits [1:0] ignored (treated as 0)
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch address (= internal pc_q)
- imem_gnt_i  input  1  request accepted this cycle (req & gnt)
- imem_rvalid_i  input  1  response valid; at most one outstanding
- imem_rdata_i  input  32  response instruction
- pc_o  output  32  PC of instr_o (registered)
- instr_o  output  32  fetched instruction; 32'b0 = bubble (registered)
- valid_o  output  1  instr_o is a real instruction (registered)

## Operation
- State machine: IDLE (reset), REQ, WAIT, KILL.
- IDLE -> REQ unconditionally on first clock after reset release.
- REQ: imem_req_o=1 (gated off while skid buffer full). gnt & !redirect -> WAIT. gnt & redirect -> pc_q<=target, KILL. !gnt & redirect -> pc_q<=target, stay REQ.
- WAIT: rvalid & !redirect & !stall -> output regs load {pc_q, rdata, 1}, pc_q<=pc_q+4, REQ. rvalid & stall -> see Configuration. redirect (with or without rvalid) -> pc_q<=target; with rvalid -> REQ, else KILL.
- KILL: waits for discarded response; rvalid -> REQ. redirect in KILL updates pc_q, stays KILL.
- Output regs: stall_i & !redirect_i -> hold. Otherwise, if no instruction is delivered this cycle -> pc_o<=pc_q, instr_o<=0, valid_o<=0.
- Redirect beats stall: outputs become bubble (valid_o=0) next cycle.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); pc_q[1:0] always 0.

## Timing
- Reset values: state IDLE, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, instr_o=0, valid_o=0, skid empty.
- Reset asserted mid-transaction: all state cleared immediately; late rvalid after release is ignored (IDLE/REQ do not sample rvalid).
- Best case: gnt in request cycle N, rvalid in N+1, valid_o in N+2; throughput 1 instruction / 2 cycles.
- imem_req_o, imem_addr_o are combinational from state/pc_q; stable until gnt.

## Configuration
- IFU_SKID_EN defined: 1-entry skid buffer. rvalid while stall_i=1 captures {pc_q, rdata}, pc_q<=pc_q+4, state REQ with request gated until buffer drains. First cycle with stall_i=0 loads outputs from skid (valid_o=1). Redirect clears skid.
- IFU_SKID_EN undefined: rvalid while stall_i=1 drops the data, pc_q unchanged, state REQ (same PC refetched once stall_i=0; no request issued while stall_i=1).

## Structure
- Package ifu_pkg: state enum (IDLE/REQ/WAIT/KILL), BUBBLE_INSTR=32'b0, PC increment constant 4, default RESET_PC.
- Sub-module ifu_skid_buffer (1-entry, pc+instr+valid, load/drain/clear), instantiated only under IFU_SKID_EN.

## Test plan
- Reset release, gnt immediate, rvalid 1 cycle later with 32'h00500093 -> cycle N+2: pc_o=0, instr_o=32'h00500093, valid_o=1; next request addr 4.
- redirect_i=1 target=32'h100 while in WAIT, rvalid 2 cycles later -> response discarded, next imem_addr_o=32'h100, valid_o=0 meanwhile.
- stall_i=1 for 3 cycles with rvalid during stall -> outputs hold; SKID_EN: instr delivered first unstalled cycle, no refetch; else addr refetched after stall.
- redirect_i and stall_i same cycle -> valid_o=0, instr_o=0 next cycle, pc_q=target.
- pc_q=32'hFFFF_FFFC fetch completes -> next imem_addr_o=32'h0.
- rst_ni low while in WAIT, rvalid arrives after release -> ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t      - fetch FSM states (IDLE, REQ, WAIT, KILL)
//   BUBBLE_INSTR     - encoding presented on instr_o when no instruction is valid
//   PC_INC           - sequential PC step
//   RESET_PC_DEFAULT - default first fetch address after reset
//   align_pc/next_pc - word alignment and wrapping sequential increment
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      KILL = 2'd3
   } ifu_state_t;

   localparam logic [31:0] BUBBLE_INSTR     = 32'b0;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   // 32-bit add: 32'hFFFF_FFFC wraps to 0.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/ifu_skid_buffer.sv
// ifu_skid_buffer: one-entry holding register for a fetched instruction that
// arrived while the decode stage was stalled. Only built when IFU_SKID_EN is
// defined.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   load                - capture load_pc/load_instr, mark entry valid
//   drain               - entry consumed by the output registers
//   clear               - discard entry (branch redirect); wins over load
//   load_pc, load_instr - data to capture
//   valid, pc, instr    - stored entry
module ifu_skid_buffer
   import ifu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

   // Payload is only meaningful while valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         pc    <= load_pc;
         instr <= load_instr;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage. Owns the PC, issues one outstanding request at a
// time to instruction memory (req/gnt/rvalid) and drives the IF/ID register
// (pc_o/instr_o/valid_o), inserting zero bubbles when nothing is available.
// Optional macro IFU_SKID_EN: keep a response that arrives during a stall in a
// one-entry skid buffer instead of dropping it and refetching.
// Ports:
//   clk_i, rst_ni                        - clock, asynchronous active-low reset
//   stall_i                              - hold IF/ID outputs
//   redirect_i, target_i                 - taken branch/jump and its target
//   imem_req_o, imem_addr_o, imem_gnt_i  - request handshake
//   imem_rvalid_i, imem_rdata_i          - response
//   pc_o, instr_o, valid_o               - registered IF/ID outputs
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   ifu_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target;
   logic        fire, rsp, capture, hold_fetch;
   logic        skid_full, skid_drain;
   logic [31:0] skid_pc, skid_instr;

   assign target      = align_pc(target_i);
   assign rsp         = (state_q == WAIT) && imem_rvalid_i;
   // Response that cannot be delivered because decode is stalled.
   assign capture     = rsp && stall_i && !redirect_i;
   assign skid_drain  = skid_full && !stall_i && !redirect_i;
   assign imem_req_o  = (state_q == REQ) && !hold_fetch;
   assign imem_addr_o = pc_q;
   assign fire        = imem_req_o && imem_gnt_i;

`ifdef IFU_SKID_EN
   ifu_skid_buffer u_skid (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .load       (capture),
      .drain      (skid_drain),
      .clear      (redirect_i),
      .load_pc    (pc_q),
      .load_instr (imem_rdata_i),
      .valid      (skid_full),
      .pc         (skid_pc),
      .instr      (skid_instr)
   );
   // No new request until the held instruction has gone downstream.
   assign hold_fetch = skid_full;
`else
   logic drop_q;

   // Set when a stalled response was thrown away; blocks the refetch until
   // the stall lifts so the same response cannot be dropped repeatedly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_q <= 1'b0;
      end else if (capture) begin
         drop_q <= 1'b1;
      end else if (!stall_i || redirect_i) begin
         drop_q <= 1'b0;
      end
   end

   assign hold_fetch = drop_q;
   assign skid_full  = 1'b0;
   assign skid_pc    = '0;
   assign skid_instr = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pc_q    <= align_pc(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect_i) pc_d = target;
            // A granted request that is redirected must still be drained.
            if (fire) state_d = redirect_i ? KILL : WAIT;
         end
         WAIT: begin
            if (redirect_i) begin
               pc_d    = target;
               state_d = imem_rvalid_i ? REQ : KILL;
            end else if (imem_rvalid_i) begin
               state_d = REQ;
`ifdef IFU_SKID_EN
               pc_d = next_pc(pc_q);
`else
               // A dropped response leaves the PC in place for the refetch.
               if (!stall_i) pc_d = next_pc(pc_q);
`endif
            end
         end
         KILL: begin
            if (redirect_i) pc_d = target;
            if (imem_rvalid_i) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   // IF/ID register: redirect squashes, otherwise stall holds.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_o    <= '0;
         instr_o <= BUBBLE_INSTR;
         valid_o <= 1'b0;
      end else if (redirect_i || !stall_i) begin
         if (skid_drain) begin
            pc_o    <= skid_pc;
            instr_o <= skid_instr;
            valid_o <= 1'b1;
         end else if (rsp && !redirect_i) begin
            pc_o    <= pc_q;
            instr_o <= imem_rdata_i;
            valid_o <= 1'b1;
         end else begin
            pc_o    <= pc_q;
            instr_o <= BUBBLE_INSTR;
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit. Stimulus tasks act
// as instruction memory and push expected requests/outputs into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        valid_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } out_t;

   out_t        exp_out[$];
   logic [31:0] exp_addr[$];

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .target_i      (target),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .pc_o          (pc_o),
      .instr_o       (instr_o),
      .valid_o       (valid_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pops plus hold/squash/bubble properties.
   logic        prev_stall = 1'b0;
   logic        prev_redirect = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_instr = '0;

   always @(negedge clk) begin : mon
      out_t e;
      if (rst_n) begin
         if (prev_stall && !prev_redirect) begin
            chk("hold_pc", pc_o, prev_pc);
            chk("hold_instr", instr_o, prev_instr);
            chk("hold_valid", {31'b0, valid_o}, {31'b0, prev_valid});
         end
         if (prev_redirect) begin
            chk("squash_valid", {31'b0, valid_o}, 32'd0);
            chk("squash_instr", instr_o, 32'd0);
         end
         if (!valid_o) chk("bubble_instr", instr_o, 32'd0);
         if (valid_o && !stall) begin
            if (exp_out.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got pc=%h instr=%h expected no instruction", pc_o, instr_o);
            end else begin
               e = exp_out.pop_front();
               chk("out_pc", pc_o, e.pc);
               chk("out_instr", instr_o, e.instr);
            end
         end
         if (imem_req && gnt) begin
            if (exp_addr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_req: got addr=%h expected no request", imem_addr);
            end else begin
               chk("req_addr", imem_addr, exp_addr.pop_front());
            end
         end
         prev_stall    <= stall;
         prev_redirect <= redirect;
         prev_valid    <= valid_o;
         prev_pc       <= pc_o;
         prev_instr    <= instr_o;
      end else begin
         prev_stall    <= 1'b0;
         prev_redirect <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      if (!imem_req) begin
         total++;
         bad++;
         $display("FAIL req_timeout: got no request in 20 cycles, expected one");
      end
   endtask

   task automatic grant(input logic [31:0] a);
      exp_addr.push_back(a);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic push, input logic [31:0] pc);
      if (push) exp_out.push_back({pc, d});
      rvalid = 1'b1;
      rdata  = d;
      tick();
      rvalid = 1'b0;
      rdata  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      rst_n = 1'b1;

      // Best-case fetch: gnt at N, rvalid at N+1, output after
      wait_req();
      grant(32'h0);
      respond(32'h00500093, 1'b1, 32'h0);
      chk("lat_valid", {31'b0, valid_o}, 32'd1);
      chk("lat_pc", pc_o, 32'h0);
      chk("lat_instr", instr_o, 32'h00500093);
      chk("next_addr", imem_addr, 32'h4);
      wait_req();
      grant(32'h4);
      respond(32'h00a00113, 1'b1, 32'h4);

      // Redirect while waiting; late response discarded
      wait_req();
      grant(32'h8);
      redirect = 1'b1;
      target   = 32'h100;
      tick();
      redirect = 1'b0;
      chk("kill_no_req", {31'b0, imem_req}, 32'd0);
      tick();
      respond(32'hdeadbeef, 1'b0, 32'h0);
      wait_req();
      grant(32'h100);
      respond(32'h00000013, 1'b1, 32'h100);

      // Stall for 3 cycles with a response arriving during it
      wait_req();
      grant(32'h104);
      respond(32'h00108093, 1'b1, 32'h104);
      stall = 1'b1;
      grant(32'h108);
`ifdef IFU_SKID_EN
      exp_out.push_back({32'h108, 32'h00208113});
`endif
      rvalid = 1'b1;
      rdata  = 32'h00208113;
      tick();
      rvalid = 1'b0;
      chk("stall_no_req1", {31'b0, imem_req}, 32'd0);
      tick();
      chk("stall_no_req2", {31'b0, imem_req}, 32'd0);
      stall = 1'b0;
      wait_req();
`ifdef IFU_SKID_EN
      grant(32'h10C);
      respond(32'h00308193, 1'b1, 32'h10C);
      chk("after_stall_addr", imem_addr, 32'h110);
`else
      grant(32'h108);
      respond(32'h00208113, 1'b1, 32'h108);
      chk("after_stall_addr", imem_addr, 32'h10C);
`endif

      // Redirect and stall together squash the held instruction
      wait_req();
      grant(imem_addr);
      respond(32'h0badc0de, 1'b0, 32'h0);
      stall    = 1'b1;
      redirect = 1'b1;
      target   = 32'h200;
      tick();
      stall    = 1'b0;
      redirect = 1'b0;
      chk("rs_valid", {31'b0, valid_o}, 32'd0);
      chk("rs_instr", instr_o, 32'h0);
      chk("rs_addr", imem_addr, 32'h200);
      wait_req();
      grant(32'h200);
      respond(32'h00400213, 1'b1, 32'h200);

      // Unaligned target and PC wrap
      redirect = 1'b1;
      target   = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      chk("align_addr", imem_addr, 32'hFFFF_FFFC);
      wait_req();
      grant(32'hFFFF_FFFC);
      respond(32'h00500293, 1'b1, 32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr, 32'h0);
      wait_req();
      grant(32'h0);
      respond(32'h00600313, 1'b1, 32'h0);

      // Reset while waiting, late response after release
      wait_req();
      grant(32'h4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
      tick();
      tick();
      rst_n  = 1'b1;
      rvalid = 1'b1;
      rdata  = 32'hffffffff;
      tick();
      tick();
      rvalid = 1'b0;
      rdata  = '0;
      chk("late_rsp_valid", {31'b0, valid_o}, 32'd0);
      wait_req();
      grant(32'h0);
      respond(32'h00700393, 1'b1, 32'h0);
      tick();
      tick();

      chk("out_queue_empty", 32'(exp_out.size()), 32'd0);
      chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
